// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the round-robin adder arbiter.
// Optional macro ADDER_ARB_SAT_EN selects saturating result sums.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COLLECT
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 4;
  localparam int PTR_W_DEF = $clog2(N_REQ_DEF);

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: first active request
// found scanning upward from ptr, wrapping at N.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        win[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin sharing of one registered adder among N_REQ requesters.
// Define ADDER_ARB_SAT_EN to saturate Res_Sum on carry-out.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [N_REQ-1:0]       Req,
  input  logic [N_REQ*WIDTH-1:0] Req_A,
  input  logic [N_REQ*WIDTH-1:0] Req_B,
  output logic [N_REQ-1:0]       Gnt,
  output logic [N_REQ-1:0]       Done,
  output logic [WIDTH-1:0]       Res_Sum,
  output logic                   Res_Overflow,
  output logic                   Busy,
  output logic [WIDTH-1:0]       Add_A,
  output logic [WIDTH-1:0]       Add_B,
  output logic                   Add_En,
  input  logic [WIDTH-1:0]       Add_Sum,
  input  logic                   Add_Overflow
);

  localparam int PW = ptr_w(N_REQ);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               en_q, en_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      idx_q, idx_d;

  logic [N_REQ-1:0]   pick_win;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;

  rr_picker #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req (Req),
    .ptr (ptr_q),
    .win (pick_win),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    b_d     = b_q;
    en_d    = 1'b0;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_win;
          idx_d   = pick_idx;
          a_d     = Req_A[int'(pick_idx)*WIDTH +: WIDTH];
          b_d     = Req_B[int'(pick_idx)*WIDTH +: WIDTH];
          en_d    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = COLLECT;
      end
      COLLECT: begin
`ifdef ADDER_ARB_SAT_EN
        sum_d = Add_Overflow ? '1 : Add_Sum;
`else
        sum_d = Add_Sum;
`endif
        ovf_d   = Add_Overflow;
        done_d  = gnt_q;
        gnt_d   = '0;
        ptr_d   = (int'(idx_q) == N_REQ - 1) ?
                  '0 : idx_q + PW'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The adder itself has no reset; dropping state here discards any op.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      en_q    <= 1'b0;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      en_q    <= en_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  assign Gnt          = gnt_q;
  assign Done         = done_q;
  assign Res_Sum      = sum_q;
  assign Res_Overflow = ovf_q;
  assign Busy         = (state_q != IDLE);
  assign Add_A        = a_q;
  assign Add_B        = b_q;
  assign Add_En       = en_q;

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
Shares one registered adder (posedge Clk, result captured when En high, no reset on the adder) among N_REQ requesters. Round-robin arbitration; each granted request launches one add and returns Sum/Overflow with a one-hot Done pulse. Sits between the requesting datapath blocks and the single adder instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 4, operand/sum width; must match the adder

Ports:
Clk  input  1  system clock, all logic on posedge
Reset_n  input  1  synchronous active-low reset
Req  input  N_REQ  per-requester request level
Req_A  input  N_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
Req_B  input  N_REQ*WIDTH  packed operand B, same packing
Gnt  output  N_REQ  one-hot grant, registered
Done  output  N_REQ  one-hot result-valid pulse, registered
Res_Sum  output  WIDTH  result sum, valid while Done != 0
Res_Overflow  output  1  carry-out of result, valid while Done != 0
Busy  output  1  high in ISSUE and COLLECT
Add_A  output  WIDTH  to adder A, registered
Add_B  output  WIDTH  to adder B, registered
Add_En  output  1  to adder En, registered
Add_Sum  input  WIDTH  from adder Sum
Add_Overflow  input  1  from adder Overflow

Behaviour:
- Reset (Reset_n low at posedge): state IDLE, Gnt=0, Done=0, Res_Sum=0, Res_Overflow=0, Add_A=0, Add_B=0, Add_En=0, rr pointer=0. Reset mid-operation aborts the op silently: no Done, the adder result is discarded.
- States: IDLE -> ISSUE -> COLLECT -> IDLE.
- IDLE: if any Req is high, pick the winner by round-robin, starting the search at pointer (pointer, pointer+1, ... mod N_REQ). At the edge: Gnt=onehot(winner), Add_A/Add_B = winner's operands, Add_En=1, go to ISSUE. Otherwise hold.
- ISSUE: the adder captures at the end of this cycle. At the edge: Add_En=0, go to COLLECT.
- COLLECT: at the edge: Res_Sum=Add_Sum, Res_Overflow=Add_Overflow, Done=Gnt, Gnt=0, pointer=(winner+1) mod N_REQ, go to IDLE.
- Done is a 1-cycle pulse, high during the IDLE cycle after COLLECT. Res_Sum/Res_Overflow hold their value until the next COLLECT.
- Latency: Req high in cycle 0 gives Gnt in cycles 1-2 and Done in cycle 3. Back-to-back throughput is one add per 3 cycles; arbitration runs in the same cycle that Done is high.
- Handshake: operands are sampled only at the grant edge; the requester may change them after Gnt rises. Req must drop in the Done cycle, otherwise it counts as a new request (it is lowest priority because the pointer has moved past it).
- Req dropped during ISSUE/COLLECT: the op still completes and Done still pulses.
- Arithmetic: {Overflow,Sum} = A + B, unsigned, WIDTH+1 bits.
- Pointer wraps from N_REQ-1 to 0.
- Invariants: Add_En is never high for two consecutive cycles; Gnt and Done are never both nonzero.

Optional Feature:
ADDER_ARB_SAT_EN
- Defined: in COLLECT, if Add_Overflow=1 then Res_Sum={WIDTH{1'b1}}, otherwise Add_Sum. Res_Overflow still reports the carry.
- Undefined: Res_Sum=Add_Sum (wrap-around).
- Latency and handshake are unchanged in both cases.

Decomposition:
- Package adder_arb_pkg: state enum (IDLE, ISSUE, COLLECT), default N_REQ/WIDTH constants, pointer width localparam ($clog2(N_REQ)).
- Sub-module rr_picker: combinational. Inputs Req and pointer; outputs one-hot winner, winner index and any_req. Reusable by other arbiters.

Test Plan:
- Reset: hold Reset_n=0 with Req=4'b1111 -> all outputs 0, Add_En never high; after release, requester 0 is granted first.
- Single request: Req=4'b0100, A2=4'h3, B2=4'h4 -> Gnt=4'b0100 in cycles 1-2, Add_En=1 in cycle 1 only, Done=4'b0100 in cycle 3, Res_Sum=4'h7, Res_Overflow=0.
- Overflow: A=4'hF, B=4'h2 -> Res_Sum=4'h1, Res_Overflow=1. With ADDER_ARB_SAT_EN: Res_Sum=4'hF, Res_Overflow=1.
- Round-robin fairness: Req=4'b1111 held, dropping each requester's Req in its Done cycle -> grant order 0,1,2,3, one Done every 3 cycles.
- Persistent requester: Req0 stays high, Req2 toggles on -> grant order 0,2,0,2; requester 0 is not starved and cannot monopolise.
- Reset mid-operation: assert Reset_n=0 during COLLECT -> no Done pulse, pointer=0, next grant goes to the lowest active index.
